multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that drives the datapath around the ALU: it sequences fetch, decode, execute, memory and writeback.
- Produces alu_op/shamt and all datapath enables for a MIPS-style integer subset.
- Consumes the instruction word, the branch-compare flags (equal/not_equal from the separate compare block) and a memory req/ack handshake.
- Sits in the CPU core between the instruction register and the datapath muxes.

Parameters:
- OP_BITS, 4, width of alu_op; encodings come from the shared constants in common.vh (ALU_PASS1 … ALU_SRA).
- SHIFT_BITS, 5, width of shamt.
- INSTR_BITS, 32, instruction width.

Ports:
- clk  in  1  single core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  INSTR_BITS  current IR contents; valid from DECODE onward.
- equal  in  1  rs==rt from the compare block.
- not_equal  in  1  rs!=rt from the compare block.
- mem_ack  in  1  memory completes the pending request this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=store, 0=read/fetch; qualified by mem_req.
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_sel  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR).
- alu_op  out  OP_BITS  ALU operation.
- shamt  out  SHIFT_BITS  shift amount (instr[10:6] for shifts, else 0).
- alu_src_b  out  2  0=rt, 1=sign-ext imm, 2=zero-ext imm, 3=imm<<16.
- reg_we  out  1  register-file write enable.
- reg_dst_sel  out  2  0=rt, 1=rd, 2=r31.
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_instr  out  1  sticky flag; set on an unsupported opcode/funct.

Behaviour:
- Reset: state=FETCH; every output 0 (alu_op=ALU_PASS1 encoding 0 only if that is its code; otherwise alu_op=0); illegal_instr cleared. rst overrides every other input in the same edge.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH
  - Outputs: mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ack: ir_we=1, pc_we=1, pc_sel=0 in that same cycle, then go to DECODE. Otherwise stay.
  - mem_ack may arrive in the first request cycle (zero-wait).
- DECODE: one cycle. Classify opcode instr[31:26] / funct instr[5:0].
  - Legal opcode -> EXEC.
  - Illegal opcode -> TRAP.
- EXEC: drive alu_op, shamt and alu_src_b per instruction.
  - R-type funct mapping (alu_src_b=0):
    - 0x20/0x21 -> ADD; 0x22/0x23 -> SUB.
    - 0x24 -> AND; 0x25 -> OR; 0x27 -> NOR.
    - 0x2A -> LTS; 0x2B -> LTU.
    - 0x00 -> SLL; 0x02 -> SRL; 0x03 -> SRA.
    - 0x08 JR: pc_we=1, pc_sel=3, instr_done=1, -> FETCH.
  - I-type mapping:
    - ADDI 0x08 -> ADD, src 1.
    - SLTI 0x0A -> LTS, src 1; SLTIU 0x0B -> LTU, src 1.
    - ANDI 0x0C -> AND, src 2; ORI 0x0D -> OR, src 2.
    - LUI 0x0F -> PASS2, src 3.
    - LW 0x23 / SW 0x2B -> ADD, src 1, then -> MEM.
  - BEQ 0x04 / BNE 0x05: alu_op=SUB, src 0.
    - pc_we=1, pc_sel=1 only when equal (BEQ) or not_equal (BNE).
    - instr_done=1, -> FETCH. Not taken: pc_we=0.
  - J 0x02: pc_we=1, pc_sel=2, instr_done=1, -> FETCH.
  - JAL 0x03: same as J, plus reg_we=1, reg_dst_sel=2, wb_sel=2 in this same cycle.
  - ALU instructions -> WB.
- MEM
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=1 for SW; alu_op/alu_src_b held at ADD/1.
  - SW: on mem_ack, instr_done=1, -> FETCH.
  - LW: on mem_ack, -> WB.
- WB: one cycle.
  - reg_we=1, instr_done=1, -> FETCH.
  - reg_dst_sel=1 for R-type, 0 otherwise; wb_sel=1 for LW, 0 otherwise.
- TRAP: illegal_instr=1; all enables 0. Remain until rst.
- Unspecified funct within R-type counts as illegal.
- Timing: the FSM ignores mem_ack outside FETCH/MEM; mem_req never drops before ack.
- Minimum cycles, zero-wait memory:
  - R-type/I-ALU: 4.
  - LW: 5; SW: 4.
  - Branch/J/JR: 3.
- Outputs registered from state plus the IR decode (Moore on state, decode combinational from instr). Enables are asserted only in the stated states.

Decomposition:
- Shared package: state enum (ctrl_state_t); opcode and funct localparams; pc_sel/alu_src_b/reg_dst_sel/wb_sel encodings.
- ALU_* codes are reused from common.vh.
- One sub-module: ctrl_decode, purely combinational instr -> {alu_op, shamt, alu_src_b, class, legal}, so that it can be unit-tested separately.

Test Plan:
- ADD rd=3, rs=1, rt=2 (funct 0x20), mem_ack zero-wait -> states FETCH, DECODE, EXEC (alu_op=ALU_ADD, src 0), WB (reg_we=1, reg_dst_sel=1); instr_done on cycle 4.
- LW, mem_ack delayed 3 cycles in MEM -> mem_req=1 and mem_addr_sel=1 held 3 cycles; WB with wb_sel=1; total 7 cycles after FETCH ack.
- BEQ with equal=1 -> pc_we=1, pc_sel=1 in EXEC; repeat with equal=0 -> pc_we=0, still instr_done.
- SRA funct 0x03, instr[10:6]=5'd31 -> alu_op=ALU_SRA, shamt=31 in EXEC.
- Opcode 0x3F -> TRAP, illegal_instr=1 sticky across 10 cycles; rst -> FETCH, flag cleared.
- rst asserted in MEM during a pending SW with mem_ack low -> next cycle FETCH, mem_we=0, no instr_done pulse.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its decoder.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  // Instruction class: selects the EXEC/MEM/WB path taken after decode.
  typedef enum logic [3:0] {
    CLS_RALU = 4'd0,
    CLS_IALU = 4'd1,
    CLS_LW   = 4'd2,
    CLS_SW   = 4'd3,
    CLS_BEQ  = 4'd4,
    CLS_BNE  = 4'd5,
    CLS_J    = 4'd6,
    CLS_JAL  = 4'd7,
    CLS_JR   = 4'd8,
    CLS_ILL  = 4'd9
  } instr_class_t;

  // ALU operation codes shared with the datapath ALU.
  localparam logic [3:0] ALU_PASS1 = 4'd0;
  localparam logic [3:0] ALU_PASS2 = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_NOR   = 4'd6;
  localparam logic [3:0] ALU_LTS   = 4'd7;
  localparam logic [3:0] ALU_LTU   = 4'd8;
  localparam logic [3:0] ALU_SLL   = 4'd9;
  localparam logic [3:0] ALU_SRL   = 4'd10;
  localparam logic [3:0] ALU_SRA   = 4'd11;

  // Primary opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0].
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Datapath mux encodings.
  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_RS     = 2'd3;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SEXT = 2'd1;
  localparam logic [1:0] SRC_B_ZEXT = 2'd2;
  localparam logic [1:0] SRC_B_LUI  = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: instr -> ALU controls, class and legality.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_BITS    = 4,
  parameter int SHIFT_BITS = 5,
  parameter int INSTR_BITS = 32
) (
  input  logic [INSTR_BITS-1:0] instr,
  output logic [OP_BITS-1:0]    alu_op,
  output logic [SHIFT_BITS-1:0] shamt,
  output logic [1:0]            alu_src_b,
  output instr_class_t          cls,
  output logic                  legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  // Register specifiers and immediates are routed by the datapath, not here.
  assign unused_fields = ^instr[25:11];

  // Map opcode/funct to ALU op, B-operand source and the FSM path class.
  always_comb begin
    alu_op    = OP_BITS'(ALU_PASS1);
    shamt     = '0;
    alu_src_b = SRC_B_RT;
    cls       = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_ADD); end
          FN_SUB, FN_SUBU: begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_SUB); end
          FN_AND:          begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_AND); end
          FN_OR:           begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_OR);  end
          FN_NOR:          begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_NOR); end
          FN_SLT:          begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_LTS); end
          FN_SLTU:         begin cls = CLS_RALU; alu_op = OP_BITS'(ALU_LTU); end
          FN_SLL: begin
            cls    = CLS_RALU;
            alu_op = OP_BITS'(ALU_SLL);
            shamt  = SHIFT_BITS'(instr[10:6]);
          end
          FN_SRL: begin
            cls    = CLS_RALU;
            alu_op = OP_BITS'(ALU_SRL);
            shamt  = SHIFT_BITS'(instr[10:6]);
          end
          FN_SRA: begin
            cls    = CLS_RALU;
            alu_op = OP_BITS'(ALU_SRA);
            shamt  = SHIFT_BITS'(instr[10:6]);
          end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDI:  begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_ADD);   alu_src_b = SRC_B_SEXT; end
      OP_SLTI:  begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_LTS);   alu_src_b = SRC_B_SEXT; end
      OP_SLTIU: begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_LTU);   alu_src_b = SRC_B_SEXT; end
      OP_ANDI:  begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_AND);   alu_src_b = SRC_B_ZEXT; end
      OP_ORI:   begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_OR);    alu_src_b = SRC_B_ZEXT; end
      OP_LUI:   begin cls = CLS_IALU; alu_op = OP_BITS'(ALU_PASS2); alu_src_b = SRC_B_LUI;  end
      OP_LW:    begin cls = CLS_LW;   alu_op = OP_BITS'(ALU_ADD);   alu_src_b = SRC_B_SEXT; end
      OP_SW:    begin cls = CLS_SW;   alu_op = OP_BITS'(ALU_ADD);   alu_src_b = SRC_B_SEXT; end
      OP_BEQ:   begin cls = CLS_BEQ;  alu_op = OP_BITS'(ALU_SUB); end
      OP_BNE:   begin cls = CLS_BNE;  alu_op = OP_BITS'(ALU_SUB); end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILL;
    endcase
  end

  assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the datapath enables and ALU controls around it.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_BITS    = 4,
  parameter int SHIFT_BITS = 5,
  parameter int INSTR_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_BITS-1:0] instr,
  input  logic                  equal,
  input  logic                  not_equal,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [OP_BITS-1:0]    alu_op,
  output logic [SHIFT_BITS-1:0] shamt,
  output logic [1:0]            alu_src_b,
  output logic                  reg_we,
  output logic [1:0]            reg_dst_sel,
  output logic [1:0]            wb_sel,
  output logic                  instr_done,
  output logic                  illegal_instr
);

  ctrl_state_t               state_q;
  ctrl_state_t               state_d;
  logic [OP_BITS-1:0]        dec_alu_op;
  logic [SHIFT_BITS-1:0]     dec_shamt;
  logic [1:0]                dec_alu_src_b;
  instr_class_t              dec_cls;
  logic                      dec_legal;

  multicycle_ctrl_decode #(
    .OP_BITS    (OP_BITS),
    .SHIFT_BITS (SHIFT_BITS),
    .INSTR_BITS (INSTR_BITS)
  ) u_ctrl_decode (
    .instr     (instr),
    .alu_op    (dec_alu_op),
    .shamt     (dec_shamt),
    .alu_src_b (dec_alu_src_b),
    .cls       (dec_cls),
    .legal     (dec_legal)
  );

  // State register; reset always lands in FETCH, which also clears the trap.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next state and datapath controls from the current state, decode and handshakes.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_SEL_PC4;
    alu_op        = '0;
    shamt         = '0;
    alu_src_b     = SRC_B_RT;
    reg_we        = 1'b0;
    reg_dst_sel   = DST_RT;
    wb_sel        = WB_ALU;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        alu_op    = dec_alu_op;
        shamt     = dec_shamt;
        alu_src_b = dec_alu_src_b;
        case (dec_cls)
          CLS_RALU, CLS_IALU: state_d = ST_WB;
          CLS_LW, CLS_SW:     state_d = ST_MEM;
          CLS_BEQ, CLS_BNE: begin
            pc_we      = (dec_cls == CLS_BEQ) ? equal : not_equal;
            pc_sel     = PC_SEL_BRANCH;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_J, CLS_JAL: begin
            pc_we      = 1'b1;
            pc_sel     = PC_SEL_JUMP;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
            // JAL links PC+4 into r31 while the jump is taken.
            if (dec_cls == CLS_JAL) begin
              reg_we      = 1'b1;
              reg_dst_sel = DST_R31;
              wb_sel      = WB_PC4;
            end
          end
          CLS_JR: begin
            pc_we      = 1'b1;
            pc_sel     = PC_SEL_RS;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        // Address add stays on the ALU for the whole access.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == CLS_SW);
        alu_op       = dec_alu_op;
        shamt        = dec_shamt;
        alu_src_b    = dec_alu_src_b;
        if (mem_ack) begin
          if (dec_cls == CLS_SW) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        alu_op      = dec_alu_op;
        shamt       = dec_shamt;
        alu_src_b   = dec_alu_src_b;
        reg_we      = 1'b1;
        reg_dst_sel = (dec_cls == CLS_RALU) ? DST_RD : DST_RT;
        wb_sel      = (dec_cls == CLS_LW) ? WB_MEM : WB_ALU;
        instr_done  = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_instr = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset wins over everything: all controls low while it is held.
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = '0;
      alu_op        = '0;
      shamt         = '0;
      alu_src_b     = '0;
      reg_we        = 1'b0;
      reg_dst_sel   = '0;
      wb_sel        = '0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule
